branch_resolve_unit: RTL and testbench

- Consumer side of the 4-bit compare-condition interface used by the datapath.
- Accepts branch micro-ops carrying a condition code, two operands, a PC, an offset and the predicted direction.
- Resolves taken/not-taken, computes the next PC, and flags mispredicts to the fetch redirect path.
- 2-stage valid/ready pipeline with flush; also keeps a saturating mispredict counter.

---
 rtl/branch_resolve_unit.sv | 120 ++++++++++++
 tb/tb_branch_resolve_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - two-stage branch resolver with redirect flagging and mispredict counter
module branch_resolve_unit #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 32,
  parameter int TAG_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_cond,
  input  logic [WIDTH-1:0]  in_op1,
  input  logic [WIDTH-1:0]  in_op2,
  input  logic [ADDR_W-1:0] in_pc,
  input  logic [ADDR_W-1:0] in_offset,
  input  logic              in_pred_taken,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_taken,
  output logic [ADDR_W-1:0] out_next_pc,
  output logic              out_mispredict,
  output logic [TAG_W-1:0]  out_tag,
  output logic [15:0]       mispredict_count
);

  // Stage S1: raw micro-op as accepted
  logic              s1_valid;
  logic [3:0]        s1_cond;
  logic [WIDTH-1:0]  s1_op1;
  logic [WIDTH-1:0]  s1_op2;
  logic [ADDR_W-1:0] s1_pc;
  logic [ADDR_W-1:0] s1_offset;
  logic              s1_pred;
  logic [TAG_W-1:0]  s1_tag;

  logic              s2_free;
  logic              out_fire;
  logic              s1_taken;
  logic [ADDR_W-1:0] s1_target;
  logic [ADDR_W-1:0] s1_fall;

  assign s2_free  = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_free;
  assign out_fire = out_valid && out_ready;

  // Both candidate PCs wrap modulo 2^ADDR_W
  assign s1_target = s1_pc + s1_offset;
  assign s1_fall   = s1_pc + ADDR_W'(4);

  // Evaluate the branch predicate on the S1 operands; codes 9..15 are never taken
  always_comb begin
    s1_taken = 1'b0;
    case (s1_cond)
      4'd0:    s1_taken = (s1_op1 == '0);
      4'd1:    s1_taken = (s1_op1 != '0);
      4'd2:    s1_taken = 1'b1;
      4'd3:    s1_taken = ($signed(s1_op1) >= $signed(s1_op2));
      4'd4:    s1_taken = ($signed(s1_op1) <  $signed(s1_op2));
      4'd5:    s1_taken = (s1_op1 >= s1_op2);
      4'd6:    s1_taken = (s1_op1 <  s1_op2);
      4'd7:    s1_taken = (s1_op1 == s1_op2);
      4'd8:    s1_taken = (s1_op1 != s1_op2);
      default: s1_taken = 1'b0;
    endcase
  end

  // Pipeline registers, flush and the mispredict counter
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid         <= 1'b0;
      s1_cond          <= '0;
      s1_op1           <= '0;
      s1_op2           <= '0;
      s1_pc            <= '0;
      s1_offset        <= '0;
      s1_pred          <= 1'b0;
      s1_tag           <= '0;
      out_valid        <= 1'b0;
      out_taken        <= 1'b0;
      out_next_pc      <= '0;
      out_mispredict   <= 1'b0;
      out_tag          <= '0;
      mispredict_count <= '0;
    end else begin
      // The consumer owns a beat transferred on a flush edge, so it still counts
      if (out_fire && out_mispredict && (mispredict_count != 16'hFFFF))
        mispredict_count <= mispredict_count + 16'd1;

      if (flush) begin
        s1_valid  <= 1'b0;
        out_valid <= 1'b0;
      end else begin
        if (s2_free) begin
          out_valid <= s1_valid;
          if (s1_valid) begin
            out_taken      <= s1_taken;
            out_next_pc    <= s1_taken ? s1_target : s1_fall;
            out_mispredict <= s1_taken ^ s1_pred;
            out_tag        <= s1_tag;
          end
        end
        if (in_ready) begin
          s1_valid <= in_valid;
          if (in_valid) begin
            s1_cond   <= in_cond;
            s1_op1    <= in_op1;
            s1_op2    <= in_op2;
            s1_pc     <= in_pc;
            s1_offset <= in_offset;
            s1_pred   <= in_pred_taken;
            s1_tag    <= in_tag;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - directed vector bench for branch_resolve_unit
module tb_branch_resolve_unit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_cond;
  logic [31:0] in_op1;
  logic [31:0] in_op2;
  logic [31:0] in_pc;
  logic [31:0] in_offset;
  logic        in_pred_taken;
  logic [3:0]  in_tag;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic        out_taken;
  logic [31:0] out_next_pc;
  logic        out_mispredict;
  logic [3:0]  out_tag;
  logic [15:0] mispredict_count;

  branch_resolve_unit #(.WIDTH(32), .ADDR_W(32), .TAG_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_cond(in_cond),
    .in_op1(in_op1), .in_op2(in_op2), .in_pc(in_pc), .in_offset(in_offset),
    .in_pred_taken(in_pred_taken), .in_tag(in_tag), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_taken(out_taken),
    .out_next_pc(out_next_pc), .out_mispredict(out_mispredict),
    .out_tag(out_tag), .mispredict_count(mispredict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  cond;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] pc;
    logic [31:0] off;
    logic        pred;
    logic [3:0]  tag;
    logic        exp_taken;
    logic [31:0] exp_npc;
    logic        exp_mis;
  } vec_t;

  vec_t        vecs[$];
  int          checks;
  int          errors;
  logic [15:0] exp_count;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] pc, input logic [31:0] off, input logic p,
                              input logic t, input logic [31:0] npc);
    vec_t v;
    v.cond = c; v.op1 = a; v.op2 = b; v.pc = pc; v.off = off; v.pred = p;
    v.tag = 4'(vecs.size());
    v.exp_taken = t; v.exp_npc = npc; v.exp_mis = t ^ p;
    return v;
  endfunction

  task automatic drive_op(input vec_t v);
    in_valid = 1'b1; in_cond = v.cond; in_op1 = v.op1; in_op2 = v.op2;
    in_pc = v.pc; in_offset = v.off; in_pred_taken = v.pred; in_tag = v.tag;
  endtask

  // One op through an empty pipe with out_ready held high
  task automatic send_one(input vec_t v);
    @(negedge clk);
    drive_op(v);
    check("accept_ready", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    check("latency_not_yet", out_valid, 1'b0);
    @(negedge clk);
    check("out_valid", out_valid, 1'b1);
    check("out_taken", out_taken, v.exp_taken);
    check("out_next_pc", out_next_pc, v.exp_npc);
    check("out_mispredict", out_mispredict, v.exp_mis);
    check("out_tag", out_tag, v.tag);
    @(negedge clk);
    if (v.exp_mis && exp_count != 16'hFFFF) exp_count++;
    check("count_after", mispredict_count, exp_count);
    check("drained", out_valid, 1'b0);
  endtask

  initial begin
    logic [15:0] sweep_mask;
    logic [3:0]  pat;
    logic        m_s1, m_s2, s2f, exp_rdy, saw_stall;
    int          idx, recv, sent, n;
    vec_t        v;

    checks = 0; errors = 0; exp_count = 16'd0;
    rst = 1'b1; in_valid = 1'b0; in_cond = '0; in_op1 = '0; in_op2 = '0;
    in_pc = '0; in_offset = '0; in_pred_taken = 1'b0; in_tag = '0;
    flush = 1'b0; out_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_next_pc", out_next_pc, 32'h0);
    check("rst_tag", out_tag, 4'h0);
    check("rst_count", mispredict_count, 16'h0);
    rst = 1'b0;
    check("rst_in_ready", in_ready, 1'b1);

    // Vector table
    vecs.push_back(mk(4'd3, 32'hFFFFFFFF, 32'h1, 32'h100, 32'h20, 1'b1, 1'b0, 32'h104));
    vecs.push_back(mk(4'd5, 32'hFFFFFFFF, 32'h1, 32'h100, 32'h20, 1'b1, 1'b1, 32'h120));
    vecs.push_back(mk(4'd4, 32'hFFFFFFFF, 32'h1, 32'h100, 32'h20, 1'b0, 1'b1, 32'h120));
    vecs.push_back(mk(4'd6, 32'hFFFFFFFF, 32'h1, 32'h100, 32'h20, 1'b0, 1'b0, 32'h104));
    vecs.push_back(mk(4'd8, 32'h1, 32'h2, 32'h1000, 32'hFFFFFFF0, 1'b1, 1'b1, 32'hFF0));
    vecs.push_back(mk(4'd1, 32'h5, 32'h0, 32'h300, 32'h10, 1'b0, 1'b1, 32'h310));
    sweep_mask = 16'h00AD;
    for (int c = 0; c < 16; c++)
      vecs.push_back(mk(4'(c), 32'h0, 32'h0, 32'h200, 32'h40, 1'b0, sweep_mask[c],
                        sweep_mask[c] ? 32'h240 : 32'h204));
    vecs.push_back(mk(4'd2, 32'h0, 32'h0, 32'hFFFFFFFC, 32'h8, 1'b1, 1'b1, 32'h4));
    vecs.push_back(mk(4'd9, 32'h0, 32'h0, 32'hFFFFFFFC, 32'h8, 1'b0, 1'b0, 32'h0));

    foreach (vecs[i]) send_one(vecs[i]);

    // Stream 4 ops while out_ready toggles 1,0,0,1
    pat = 4'b1001; idx = 0; recv = 0; m_s1 = 1'b0; m_s2 = 1'b0; saw_stall = 1'b0;
    for (int cyc = 0; cyc < 40 && recv < 4; cyc++) begin
      @(negedge clk);
      out_ready = pat[cyc % 4];
      if (idx < 4) begin
        v = mk(4'd2, 32'h0, 32'h0, 32'h400, 32'h8, 1'b1, 1'b1, 32'h408);
        v.tag = 4'(idx + 1);
        drive_op(v);
      end else in_valid = 1'b0;
      #1;
      s2f = !m_s2 || out_ready;
      exp_rdy = !m_s1 || s2f;
      check("stream_in_ready", in_ready, exp_rdy);
      check("stream_out_valid", out_valid, m_s2);
      if (!in_ready) saw_stall = 1'b1;
      if (out_valid && out_ready) begin
        check("stream_tag", out_tag, 4'(recv + 1));
        recv++;
      end
      if (in_valid && in_ready) idx++;
      if (s2f) m_s2 = m_s1;
      if (exp_rdy) m_s1 = in_valid;
    end
    check("stream_recv", recv, 4);
    check("stream_stalled", saw_stall, 1'b1);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("stream_no_dup", out_valid, 1'b0);
    end

    // Fill both stages, then flush with a new op on the input
    @(negedge clk);
    out_ready = 1'b0;
    v = mk(4'd9, 32'h0, 32'h0, 32'h500, 32'h8, 1'b1, 1'b0, 32'h504); v.tag = 4'd5;
    drive_op(v);
    @(negedge clk);
    v.tag = 4'd6; drive_op(v);
    @(negedge clk);
    check("full_in_ready", in_ready, 1'b0);
    check("full_out_valid", out_valid, 1'b1);
    flush = 1'b1; v.tag = 4'd7; drive_op(v);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    check("flush_out_valid", out_valid, 1'b0);
    check("flush_in_ready", in_ready, 1'b1);
    repeat (4) begin
      @(negedge clk);
      check("flush_no_beat", out_valid, 1'b0);
    end
    check("flush_count", mispredict_count, exp_count);

    // Output transfer on the flush edge is still counted
    @(negedge clk);
    drive_op(v);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("ff_out_valid", out_valid, 1'b1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    exp_count++;
    check("ff_count", mispredict_count, exp_count);
    check("ff_out_valid_clr", out_valid, 1'b0);

    // Saturation: stream mispredicts up to 0xFFFE, then cross the boundary
    n = 32'hFFFE - int'(exp_count);
    sent = 0; recv = 0;
    v = mk(4'd9, 32'h0, 32'h0, 32'h600, 32'h8, 1'b1, 1'b0, 32'h604);
    for (int cyc = 0; cyc < 70000 && recv < n; cyc++) begin
      @(negedge clk);
      if (sent < n) drive_op(v); else in_valid = 1'b0;
      #1;
      if (out_valid) recv++;
      if (in_valid && in_ready) sent++;
    end
    check("sat_stream_recv", recv, n);
    @(negedge clk);
    in_valid = 1'b0;
    exp_count = 16'hFFFE;
    check("sat_fffe", mispredict_count, 16'hFFFE);
    for (int k = 0; k < 3; k++) send_one(v);

    // Mid-stream reset drops in-flight ops and clears the counter
    @(negedge clk);
    out_ready = 1'b0; drive_op(v);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    exp_count = 16'd0;
    check("mrst_count", mispredict_count, 16'h0);
    check("mrst_out_valid", out_valid, 1'b0);
    check("mrst_in_ready", in_ready, 1'b1);
    check("mrst_next_pc", out_next_pc, 32'h0);
    repeat (3) begin
      @(negedge clk);
      check("mrst_no_beat", out_valid, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
